sdram_wb_bridge: RTL and testbench
==================================

// Module: sdram_wb_bridge
// PURPOSE
//  Wishbone (classic, 32-bit) slave sitting directly upstream of the SDRAM controller.
//  Converts one Wishbone cycle into one controller req/ack/valid transaction:
//  - holds address, data and byte enables stable until the controller acknowledges;
//  - returns read data on the controller's valid pulse;
//  - generates a single-cycle wb_ack_o.
//  Serves the CPU data/instruction bus fabric.
// PARAMETERS
//  ADDR_WIDTH  26  byte-address width of the controller interface (64 MiB)
//  DATA_WIDTH  32  data width; only 32 is supported
// PORTS
//  clk         in   1           system clock; one clock domain, shared with the SDRAM controller
//  reset       in   1           synchronous, active-high reset
//  wb_cyc_i    in   1           Wishbone cycle
//  wb_stb_i    in   1           Wishbone strobe
//  wb_we_i     in   1           1 = write
//  wb_sel_i    in   4           byte selects, active-high
//  wb_addr_i   in   ADDR_WIDTH  byte address; bits [1:0] are ignored
//  wb_dat_i    in   32          write data
//  wb_dat_o    out  32          read data, valid while wb_ack_o is high
//  wb_ack_o    out  1           one-cycle transfer acknowledge
//  ctrl_req    out  1           request to the controller
//  ctrl_we     out  1           write enable to the controller
//  ctrl_addr   out  ADDR_WIDTH  {wb_addr_i[ADDR_WIDTH-1:2], 2'b00}
//  ctrl_data   out  32          write data
//  ctrl_bwe    out  4           byte write enables, active-high; 4'hF on reads
//  ctrl_ack    in   1           controller accepted the request (pulse at start of Active)
//  ctrl_valid  in   1           read data valid (one-cycle pulse)
//  ctrl_q      in   32          read data
// BEHAVIOUR
//  Reset values: wb_ack_o=0, wb_dat_o=0, ctrl_req=0, ctrl_we=0, ctrl_addr=0,
//    ctrl_data=0, ctrl_bwe=0. FSM goes to IDLE.
//  All outputs are registered. FSM states:
//  - IDLE:
//    - If wb_cyc_i & wb_stb_i: latch addr, data, sel and we into the ctrl_* registers,
//      set ctrl_req=1, go to REQ.
//    - Reads drive ctrl_bwe=4'hF.
//  - REQ: ctrl_req held at 1; ctrl_* stay frozen. On ctrl_ack: ctrl_req=0 in the next cycle.
//    - Write: go to RESP.
//    - Read: go to WAIT_RD.
//  - WAIT_RD: on ctrl_valid, wb_dat_o<=ctrl_q and go to RESP. If ctrl_ack and ctrl_valid
//    coincide in REQ, treat the pair as ack followed by valid (go straight to RESP with data).
//  - RESP: wb_ack_o=1 for exactly one cycle, then IDLE.
//    - wb_stb_i is not resampled until IDLE, so a held strobe starts a new transfer
//      no earlier than one cycle after the ack.
//  Minimum latencies, measured from the request cycle to the wb_ack_o cycle:
//    - write: 1 + controller ack delay + 1.
//    - read: additionally, the wait to ctrl_valid.
//  Abort: if wb_cyc_i falls in REQ or WAIT_RD, the controller transaction still completes.
//    - The FSM sets an 'orphan' flag; on completion it returns to IDLE without wb_ack_o.
//    - An orphaned read discards its data.
//  Reset mid-transaction: ctrl_req drops the next cycle and the FSM goes to IDLE.
//    The controller shares reset, so no stale valid is expected. A ctrl_valid seen in IDLE is ignored.
//  A ctrl_ack or ctrl_valid arriving in IDLE or RESP is ignored.
// CONFIGURATION
//  SDRAM_WB_RDBUF_EN defined:
//  - Adds a one-word read buffer: tag ADDR_WIDTH-2 bits, a data word and a valid bit.
//  - Buffer valid bit resets to 0.
//  - Completed non-orphan reads fill the buffer.
//  - Read hit in IDLE (tag match & valid): no controller request.
//    wb_dat_o<=buffer, go to RESP, giving an ack 2 cycles after stb.
//  - Write to the buffered tag: merges wb_dat_i bytes per wb_sel_i into the buffer
//    at the same time the write request is issued (write-through).
//  SDRAM_WB_RDBUF_EN undefined:
//  - No buffer; every read goes to the controller.
// TESTING
//  1. Write 32'hDEADBEEF to 0x100, sel=4'hF; model ack after 3 cycles.
//     -> ctrl_req high 3 cycles, ctrl_bwe=4'hF, one wb_ack_o.
//  2. Read 0x100; model ack, then valid 6 cycles later with q=32'hDEADBEEF.
//     -> wb_dat_o=32'hDEADBEEF on the wb_ack_o cycle.
//  3. Write sel=4'b0010, data 32'h0000AA00, to 0x104.
//     -> ctrl_bwe=4'b0010, ctrl_addr=0x104.
//     Address 0x107 -> ctrl_addr=0x104.
//  4. Read request, then drop wb_cyc_i in WAIT_RD.
//     -> no wb_ack_o; the next request is issued only after ctrl_valid.
//  5. Assert reset in REQ.
//     -> ctrl_req=0 and all outputs at reset values on the next cycle.
//  6. (RDBUF_EN) Read 0x200 twice.
//     -> second read issues no ctrl_req; ack 2 cycles after stb with the same data.
//     Write sel=4'h1 to 0x200, then read -> merged byte returned.

Source files
------------

// File: rtl/sdram_wb_bridge.sv
// Wishbone classic slave that turns each bus cycle into one SDRAM controller req/ack/valid transaction.
// Define SDRAM_WB_RDBUF_EN to add a one-word write-through read buffer in front of the controller.
module sdram_wb_bridge #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic [ADDR_WIDTH-1:0]   wb_addr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    ctrl_req,
    output logic                    ctrl_we,
    output logic [ADDR_WIDTH-1:0]   ctrl_addr,
    output logic [DATA_WIDTH-1:0]   ctrl_data,
    output logic [DATA_WIDTH/8-1:0] ctrl_bwe,
    input  logic                    ctrl_ack,
    input  logic                    ctrl_valid,
    input  logic [DATA_WIDTH-1:0]   ctrl_q
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RD, S_RESP} state_t;

    state_t                state_q, state_d;
    logic                  orphan_q, orphan_d;
    logic                  wb_ack_q, wb_ack_d;
    logic [DATA_WIDTH-1:0] wb_dat_q, wb_dat_d;
    logic                  ctrl_req_q, ctrl_req_d;
    logic                  ctrl_we_q, ctrl_we_d;
    logic [ADDR_WIDTH-1:0] ctrl_addr_q, ctrl_addr_d;
    logic [DATA_WIDTH-1:0] ctrl_data_q, ctrl_data_d;
    logic [SEL_WIDTH-1:0]  ctrl_bwe_q, ctrl_bwe_d;

    logic                  start;
    logic                  orphan_now;
    logic                  rd_done;
    logic                  rd_hit;
    logic [DATA_WIDTH-1:0] buf_rd_data;
    logic                  unused_addr_lsbs;

    // A strobe still high during the ack cycle belongs to the transfer just finished.
    assign start            = wb_cyc_i & wb_stb_i & ~wb_ack_q;
    assign orphan_now       = orphan_q | ~wb_cyc_i;
    assign rd_done          = ctrl_valid & ((state_q == S_WAIT_RD) |
                                            ((state_q == S_REQ) & ctrl_ack & ~ctrl_we_q));
    assign unused_addr_lsbs = ^wb_addr_i[1:0];

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
        state_d     = state_q;
        orphan_d    = orphan_q;
        wb_ack_d    = 1'b0;
        wb_dat_d    = wb_dat_q;
        ctrl_req_d  = ctrl_req_q;
        ctrl_we_d   = ctrl_we_q;
        ctrl_addr_d = ctrl_addr_q;
        ctrl_data_d = ctrl_data_q;
        ctrl_bwe_d  = ctrl_bwe_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    orphan_d = 1'b0;
                    if (rd_hit) begin
                        wb_dat_d = buf_rd_data;
                        state_d  = S_RESP;
                    end else begin
                        ctrl_req_d  = 1'b1;
                        ctrl_we_d   = wb_we_i;
                        ctrl_addr_d = {wb_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        ctrl_data_d = wb_dat_i;
                        ctrl_bwe_d  = wb_we_i ? wb_sel_i : '1;
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                orphan_d = orphan_now;
                if (ctrl_ack) begin
                    ctrl_req_d = 1'b0;
                    if (ctrl_we_q || rd_done) begin
                        state_d = orphan_now ? S_IDLE : S_RESP;
                    end else begin
                        state_d = S_WAIT_RD;
                    end
                end
            end
            S_WAIT_RD: begin
                orphan_d = orphan_now;
                if (rd_done) begin
                    state_d = orphan_now ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                wb_ack_d = 1'b1;
                state_d  = S_IDLE;
            end
        endcase

        // An abandoned read still completes on the controller, but its data is dropped.
        if (rd_done && !orphan_now) begin
            wb_dat_d = ctrl_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            orphan_q    <= 1'b0;
            wb_ack_q    <= 1'b0;
            wb_dat_q    <= '0;
            ctrl_req_q  <= 1'b0;
            ctrl_we_q   <= 1'b0;
            ctrl_addr_q <= '0;
            ctrl_data_q <= '0;
            ctrl_bwe_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples values from before the edge.
            state_q     <= state_d;
            orphan_q    <= orphan_d;
            wb_ack_q    <= wb_ack_d;
            wb_dat_q    <= wb_dat_d;
            ctrl_req_q  <= ctrl_req_d;
            ctrl_we_q   <= ctrl_we_d;
            ctrl_addr_q <= ctrl_addr_d;
            ctrl_data_q <= ctrl_data_d;
            ctrl_bwe_q  <= ctrl_bwe_d;
        end
    end

`ifdef SDRAM_WB_RDBUF_EN
    logic [ADDR_WIDTH-3:0] buf_tag_q, buf_tag_d;
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic                  buf_valid_q, buf_valid_d;
    logic                  buf_match;

    assign buf_match   = buf_valid_q & (buf_tag_q == wb_addr_i[ADDR_WIDTH-1:2]);
    assign rd_hit      = buf_match & ~wb_we_i;
    assign buf_rd_data = buf_data_q;

    always_comb begin
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        buf_valid_d = buf_valid_q;
        if (rd_done && !orphan_now) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = ctrl_addr_q[ADDR_WIDTH-1:2];
            buf_data_d  = ctrl_q;
        end else if ((state_q == S_IDLE) && start && wb_we_i && buf_match) begin
            for (int b = 0; b < SEL_WIDTH; b++) begin
                if (wb_sel_i[b]) begin
                    buf_data_d[8*b +: 8] = wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    // NOTE: only the valid bit is reset; tag and data are meaningless until it is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
        end
        buf_tag_q  <= buf_tag_d;
        buf_data_q <= buf_data_d;
    end
`else
    assign rd_hit      = 1'b0;
    assign buf_rd_data = '0;
`endif

    assign wb_ack_o  = wb_ack_q;
    assign wb_dat_o  = wb_dat_q;
    assign ctrl_req  = ctrl_req_q;
    assign ctrl_we   = ctrl_we_q;
    assign ctrl_addr = ctrl_addr_q;
    assign ctrl_data = ctrl_data_q;
    assign ctrl_bwe  = ctrl_bwe_q;

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Self-checking bench for sdram_wb_bridge: behavioural SDRAM controller model plus a read-data scoreboard.
// Build with +define+SDRAM_WB_RDBUF_EN to exercise the read buffer expectations.
module tb_sdram_wb_bridge;
    localparam int AW = 26;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]    wb_sel_i;
    logic [AW-1:0] wb_addr_i;
    logic [31:0]   wb_dat_i, wb_dat_o;
    logic          wb_ack_o;
    logic          ctrl_req, ctrl_we;
    logic [AW-1:0] ctrl_addr;
    logic [31:0]   ctrl_data;
    logic [3:0]    ctrl_bwe;
    logic          ctrl_ack, ctrl_valid;
    logic [31:0]   ctrl_q;

    always #5 clk = ~clk;

    sdram_wb_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
        .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .ctrl_req(ctrl_req), .ctrl_we(ctrl_we), .ctrl_addr(ctrl_addr), .ctrl_data(ctrl_data),
        .ctrl_bwe(ctrl_bwe), .ctrl_ack(ctrl_ack), .ctrl_valid(ctrl_valid), .ctrl_q(ctrl_q)
    );

    int num_checks = 0;
    int num_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Controller model state and bus monitor counters
    int            ack_dly = 3;
    int            valid_dly = 6;
    int            cyc_n = 0;
    int            req_hi_cycles = 0;
    int            req_count = 0;
    int            ack_cnt = 0;
    int            last_req_rise = -1;
    int            last_valid_cyc = -1;
    logic          prev_req = 1'b0;
    logic          last_we = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [31:0]   last_data = '0;
    logic [3:0]    last_bwe = '0;
    logic          inject = 1'b0;
    logic [31:0]   inj_q = '0;
    logic [31:0]   mem [int];
    logic [31:0]   ref_mem [int];
    logic [31:0]   exp_q [$];

    initial begin
        int req_run = 0;
        int rd_cnt = 0;
        int rd_word = 0;
        ctrl_ack = 1'b0;
        ctrl_valid = 1'b0;
        ctrl_q = '0;
        forever begin
            @(negedge clk);
            cyc_n++;
            ctrl_ack = 1'b0;
            ctrl_valid = 1'b0;
            if (wb_ack_o === 1'b1) ack_cnt++;
            if (ctrl_req === 1'b1 && !prev_req) last_req_rise = cyc_n;
            prev_req = (ctrl_req === 1'b1);
            if (reset) begin
                req_run = 0;
                rd_cnt = 0;
            end else begin
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        ctrl_valid = 1'b1;
                        ctrl_q = mem.exists(rd_word) ? mem[rd_word] : 32'h0;
                        last_valid_cyc = cyc_n;
                    end
                end
                if (ctrl_req === 1'b1) begin
                    req_hi_cycles++;
                    req_run++;
                    if (req_run >= ack_dly) begin
                        ctrl_ack = 1'b1;
                        req_run = 0;
                        req_count++;
                        last_we = ctrl_we;
                        last_addr = ctrl_addr;
                        last_data = ctrl_data;
                        last_bwe = ctrl_bwe;
                        rd_word = int'(ctrl_addr[AW-1:2]);
                        if (ctrl_we) begin
                            mem[rd_word] = merge(mem.exists(rd_word) ? mem[rd_word] : 32'h0,
                                                 ctrl_data, ctrl_bwe);
                        end else if (valid_dly == 0) begin
                            ctrl_valid = 1'b1;
                            ctrl_q = mem.exists(rd_word) ? mem[rd_word] : 32'h0;
                            last_valid_cyc = cyc_n;
                        end else begin
                            rd_cnt = valid_dly;
                        end
                    end
                end else begin
                    req_run = 0;
                end
                if (inject) begin
                    ctrl_valid = 1'b1;
                    ctrl_q = inj_q;
                    inject = 1'b0;
                end
            end
        end
    end

    // One full Wishbone transfer; lat counts falling edges from strobe to the ack sample.
    task automatic wb_xfer(input logic we, input logic [AW-1:0] a, input logic [3:0] s,
                           input logic [31:0] d, output int lat);
        int          w;
        logic        got;
        logic [31:0] exp;
        w = int'(a[AW-1:2]);
        if (we) ref_mem[w] = merge(ref_mem.exists(w) ? ref_mem[w] : 32'h0, d, s);
        else exp_q.push_back(ref_mem.exists(w) ? ref_mem[w] : 32'h0);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i = we;
        wb_sel_i = s;
        wb_addr_i = a;
        wb_dat_i = d;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 300) begin
            @(negedge clk);
            lat++;
            if (wb_ack_o === 1'b1) got = 1'b1;
        end
        check(we ? "wr_ack_seen" : "rd_ack_seen", got, 1'b1);
        if (!we) begin
            exp = exp_q.pop_front();
            if (got) check("rd_data", wb_dat_o, exp);
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", wb_ack_o, 1'b0);
    endtask

    initial begin
        int          lat;
        int          r0;
        int          a0;
        int          h0;
        int          c_abort;
        logic [31:0] prev_dat;

        reset = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i = 1'b0;
        wb_sel_i = '0;
        wb_addr_i = '0;
        wb_dat_i = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", wb_ack_o, 1'b0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_req", ctrl_req, 1'b0);
        check("rst_we", ctrl_we, 1'b0);
        check("rst_addr", ctrl_addr, 0);
        check("rst_data", ctrl_data, 32'h0);
        check("rst_bwe", ctrl_bwe, 4'h0);
        reset = 1'b0;
        @(negedge clk);

        // Full-word write, controller acks in the third request cycle
        ack_dly = 3; valid_dly = 6;
        h0 = req_hi_cycles; a0 = ack_cnt;
        wb_xfer(1'b1, 'h100, 4'hF, 32'hDEADBEEF, lat);
        check("t1_req_cycles", req_hi_cycles - h0, 3);
        check("t1_we", last_we, 1'b1);
        check("t1_addr", last_addr, 'h100);
        check("t1_data", last_data, 32'hDEADBEEF);
        check("t1_bwe", last_bwe, 4'hF);
        check("t1_lat", lat, 5);
        check("t1_acks", ack_cnt - a0, 1);

        // Read back: valid six cycles after ack
        wb_xfer(1'b0, 'h100, 4'h3, 32'h0, lat);
        check("t2_bwe", last_bwe, 4'hF);
        check("t2_we", last_we, 1'b0);
        check("t2_lat", lat, 1 + 3 + 6 + 1);

        // Partial write with unaligned address
        ack_dly = 1; valid_dly = 2;
        wb_xfer(1'b1, 'h107, 4'b0010, 32'h0000AA00, lat);
        check("t3_addr", last_addr, 'h104);
        check("t3_bwe", last_bwe, 4'b0010);
        check("t3_data", last_data, 32'h0000AA00);
        check("t3_wr_lat", lat, 3);
        wb_xfer(1'b0, 'h104, 4'hF, 32'h0, lat);
        check("t3_rd_lat", lat, 5);

        // Ack and valid in the same cycle
        ack_dly = 2; valid_dly = 0;
        wb_xfer(1'b0, 'h100, 4'hF, 32'h0, lat);
        check("coincide_lat", lat, 4);

        // Abort a read in WAIT_RD, then queue a write behind it
        ack_dly = 1; valid_dly = 1;
        wb_xfer(1'b1, 'h300, 4'hF, 32'h12345678, lat);
        ack_dly = 2; valid_dly = 8;
        prev_dat = wb_dat_o;
        a0 = ack_cnt;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_addr_i = 'h300;
        repeat (5) @(negedge clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        c_abort = cyc_n;
        @(negedge clk);
        wb_xfer(1'b1, 'h308, 4'hF, 32'hCAFEF00D, lat);
        check("t4_acks", ack_cnt - a0, 1);
        check("t4_valid_seen", last_valid_cyc > c_abort, 1'b1);
        check("t4_req_after_valid", last_req_rise > last_valid_cyc, 1'b1);
        check("t4_dat_kept", wb_dat_o, prev_dat);
        ack_dly = 1; valid_dly = 1;
        wb_xfer(1'b0, 'h300, 4'hF, 32'h0, lat);

        // Reset while the request is outstanding
        ack_dly = 6;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'h5;
        wb_addr_i = 'h500; wb_dat_i = 32'h55AA55AA;
        repeat (2) @(negedge clk);
        check("t5_req_live", ctrl_req, 1'b1);
        reset = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        check("t5_req", ctrl_req, 1'b0);
        check("t5_ack", wb_ack_o, 1'b0);
        check("t5_dat", wb_dat_o, 32'h0);
        check("t5_we", ctrl_we, 1'b0);
        check("t5_addr", ctrl_addr, 0);
        check("t5_data", ctrl_data, 32'h0);
        check("t5_bwe", ctrl_bwe, 4'h0);
        reset = 1'b0;
        @(negedge clk);

        // Stray valid in IDLE must be ignored
        a0 = ack_cnt;
        inj_q = 32'hBAD0BAD0;
        inject = 1'b1;
        repeat (4) @(negedge clk);
        check("stray_valid_ack", ack_cnt - a0, 0);
        check("stray_valid_dat", wb_dat_o, 32'h0);

        // Repeated reads and a partial write to one word
        ack_dly = 2; valid_dly = 3;
        wb_xfer(1'b1, 'h200, 4'hF, 32'h11223344, lat);
        r0 = req_count;
        wb_xfer(1'b0, 'h200, 4'hF, 32'h0, lat);
        check("t6_rd1_req", req_count - r0, 1);
        r0 = req_count;
        wb_xfer(1'b0, 'h200, 4'hF, 32'h0, lat);
`ifdef SDRAM_WB_RDBUF_EN
        check("t6_hit_req", req_count - r0, 0);
        check("t6_hit_lat", lat, 2);
`else
        check("t6_rd2_req", req_count - r0, 1);
        check("t6_rd2_lat", lat, 1 + 2 + 3 + 1);
`endif
        r0 = req_count;
        wb_xfer(1'b1, 'h200, 4'h1, 32'h000000AB, lat);
        check("t6_wr_req", req_count - r0, 1);
        r0 = req_count;
        wb_xfer(1'b0, 'h200, 4'hF, 32'h0, lat);
`ifdef SDRAM_WB_RDBUF_EN
        check("t6_merge_req", req_count - r0, 0);
        check("t6_merge_lat", lat, 2);
`else
        check("t6_rd3_req", req_count - r0, 1);
`endif

        // Mixed traffic over a few words with varying controller timing
        for (int i = 0; i < 16; i++) begin
            logic [AW-1:0] a;
            case ($urandom_range(0, 2))
                0: a = 'h400;
                1: a = 'h404;
                default: a = 'h200;
            endcase
            ack_dly = $urandom_range(1, 3);
            valid_dly = $urandom_range(0, 3);
            wb_xfer(1'($urandom_range(0, 1)), a, 4'($urandom_range(1, 15)), $urandom, lat);
        end

        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
